cas_sort_ctrl: RTL and testbench

CAS_SORT_CTRL -- requirements
Module: cas_sort_ctrl

---
 rtl/cas_sort_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cas_sort_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_sort_ctrl.sv
// cas_sort_ctrl: collects a batch of NUM_REC records, sorts them by key with an
// odd-even transposition network driven through an external registered
// compare-and-swap unit, then streams the sorted batch out.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accept input records into buf[0..NUM_REC-1]
// SORT  | alternate issue / writeback cycles over all phases and pairs
// DRAIN | present buf[rd_idx] on the output until the last record leaves
module cas_sort_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int NUM_REC    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_last,
    output logic                  o_busy,
    output logic                  o_cas_en,
    output logic [DATA_WIDTH-1:0] o_cas_data_0,
    output logic [DATA_WIDTH-1:0] o_cas_data_1,
    input  logic [DATA_WIDTH-1:0] i_cas_data_0,
    input  logic [DATA_WIDTH-1:0] i_cas_data_1
);

    localparam int IDX_W = (NUM_REC > 2) ? $clog2(NUM_REC) : 1;
    localparam logic [IDX_W-1:0] LAST_REC  = IDX_W'(NUM_REC - 1);
    localparam logic [IDX_W-1:0] LAST_EVEN = IDX_W'(NUM_REC - 2);
    localparam logic [IDX_W-1:0] LAST_ODD  = IDX_W'((NUM_REC >= 3) ? NUM_REC - 3 : 0);

    // The key field is consumed by the external CAS unit; here it only has to be legal.
    if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH || NUM_REC < 2 || (NUM_REC % 2) != 0) begin : g_param_check
        $error("cas_sort_ctrl: illegal KEY_WIDTH/DATA_WIDTH/NUM_REC combination");
    end

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] buffer [NUM_REC];
    logic [IDX_W-1:0]      wr_idx, wr_idx_nxt;
    logic [IDX_W-1:0]      rd_idx, rd_idx_nxt;
    logic [IDX_W-1:0]      phase, phase_nxt;
    logic [IDX_W-1:0]      pair_idx, pair_idx_nxt;
    logic                  wb_cyc, wb_cyc_nxt;
    logic                  pair_last;
    logic                  in_ready;
    logic                  out_valid;
    logic                  cas_en;
    logic                  busy;
    logic                  load_we;
    logic                  sort_we;

    // Even phases end on pair (N-2,N-1), odd phases on (N-3,N-2).
    assign pair_last = phase[0] ? (pair_idx == LAST_ODD) : (pair_idx == LAST_EVEN);

    // Next-state and control decode.
    always_comb begin
        state_nxt    = state;
        wr_idx_nxt   = wr_idx;
        rd_idx_nxt   = rd_idx;
        phase_nxt    = phase;
        pair_idx_nxt = pair_idx;
        wb_cyc_nxt   = wb_cyc;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        cas_en       = 1'b0;
        busy         = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (i_in_valid) begin
                    wr_idx_nxt = wr_idx + IDX_W'(1);
                    if (wr_idx == LAST_REC) begin
                        wr_idx_nxt   = '0;
                        phase_nxt    = '0;
                        pair_idx_nxt = '0;
                        wb_cyc_nxt   = 1'b0;
                        state_nxt    = SORT;
                    end
                end
            end
            SORT: begin
                busy = 1'b1;
                if (!wb_cyc) begin
                    cas_en     = 1'b1;
                    wb_cyc_nxt = 1'b1;
                end else begin
                    wb_cyc_nxt = 1'b0;
                    if (!pair_last) begin
                        pair_idx_nxt = pair_idx + IDX_W'(2);
                    end else if (phase == LAST_REC || NUM_REC == 2) begin
                        // With two records the odd phase has no pairs, so the
                        // single even phase is the whole sort.
                        phase_nxt    = '0;
                        pair_idx_nxt = '0;
                        state_nxt    = DRAIN;
                    end else begin
                        phase_nxt    = phase + IDX_W'(1);
                        pair_idx_nxt = phase[0] ? IDX_W'(0) : IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (i_out_ready) begin
                    rd_idx_nxt = rd_idx + IDX_W'(1);
                    if (rd_idx == LAST_REC) begin
                        rd_idx_nxt = '0;
                        state_nxt  = LOAD;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= LOAD;
            wr_idx   <= '0;
            rd_idx   <= '0;
            phase    <= '0;
            pair_idx <= '0;
            wb_cyc   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_idx   <= wr_idx_nxt;
            rd_idx   <= rd_idx_nxt;
            phase    <= phase_nxt;
            pair_idx <= pair_idx_nxt;
            wb_cyc   <= wb_cyc_nxt;
        end
    end

    assign load_we = (state == LOAD) && i_in_valid && i_rst_n;
    assign sort_we = (state == SORT) && wb_cyc && i_rst_n;

    // Record buffer: filled in LOAD, rewritten by CAS results in SORT; never reset.
    always_ff @(posedge i_clk) begin
        if (load_we) begin
            buffer[wr_idx] <= i_in_data;
        end
        if (sort_we) begin
            buffer[pair_idx]              <= i_cas_data_0;
            buffer[pair_idx + IDX_W'(1)]  <= i_cas_data_1;
        end
    end

    assign o_in_ready   = in_ready & i_rst_n;
    assign o_busy       = busy;
    assign o_cas_en     = cas_en;
    assign o_cas_data_0 = cas_en ? buffer[pair_idx] : '0;
    assign o_cas_data_1 = cas_en ? buffer[pair_idx + IDX_W'(1)] : '0;
    assign o_out_valid  = out_valid;
    assign o_out_data   = out_valid ? buffer[rd_idx] : '0;
    assign o_out_last   = out_valid && (rd_idx == LAST_REC);

endmodule

// File: tb/tb_cas_sort_ctrl.sv
// Bench for cas_sort_ctrl: an 8-record 40-bit instance (32-bit key + 8-bit tag)
// and a 2-record instance, each paired with a behavioural CAS unit; sorted
// output is compared against a stable insertion sort of the loaded batch.
module tb_cas_sort_ctrl;

    localparam int DW  = 40;
    localparam int KW  = 32;
    localparam int TW  = 8;
    localparam int N   = 8;
    localparam int DW2 = 32;
    localparam int SORT_CYC = N * (N - 1);

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Free-running cycle index, read away from the edge.
    always @(posedge clk) cyc <= cyc + 1;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy, a_cas_en;
    logic [DW-1:0] a_in_data, a_out_data, a_cas_d0, a_cas_d1, a_cas_r0, a_cas_r1;
    logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy, b_cas_en;
    logic [DW2-1:0] b_in_data, b_out_data, b_cas_d0, b_cas_d1, b_cas_r0, b_cas_r1;

    cas_sort_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .NUM_REC(N)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
        .o_out_last(a_out_last), .o_busy(a_busy), .o_cas_en(a_cas_en),
        .o_cas_data_0(a_cas_d0), .o_cas_data_1(a_cas_d1),
        .i_cas_data_0(a_cas_r0), .i_cas_data_1(a_cas_r1)
    );

    cas_sort_ctrl #(.DATA_WIDTH(DW2), .KEY_WIDTH(DW2), .NUM_REC(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
        .o_out_last(b_out_last), .o_busy(b_busy), .o_cas_en(b_cas_en),
        .o_cas_data_0(b_cas_d0), .o_cas_data_1(b_cas_d1),
        .i_cas_data_0(b_cas_r0), .i_cas_data_1(b_cas_r1)
    );

    // Registered compare-and-swap units; swap only when the lower operand's key is strictly greater.
    int a_swaps = 0;
    always @(posedge clk) begin
        if (a_cas_en) begin
            if (a_cas_d0[DW-1 -: KW] > a_cas_d1[DW-1 -: KW]) begin
                a_cas_r0 <= a_cas_d1;
                a_cas_r1 <= a_cas_d0;
                a_swaps  <= a_swaps + 1;
            end else begin
                a_cas_r0 <= a_cas_d0;
                a_cas_r1 <= a_cas_d1;
            end
        end
    end

    always @(posedge clk) begin
        if (b_cas_en) begin
            b_cas_r0 <= (b_cas_d0 > b_cas_d1) ? b_cas_d1 : b_cas_d0;
            b_cas_r1 <= (b_cas_d0 > b_cas_d1) ? b_cas_d0 : b_cas_d1;
        end
    end

    // Protocol monitors: log CAS issue cycles and output-valid rises, count rule violations.
    int            a_en_q[$];
    int            a_val_q[$];
    int            b_en_q[$];
    int            b_val_q[$];
    int            a_viol = 0;
    int            b_viol = 0;
    logic          a_prev_valid = 1'b0, a_prev_ready = 1'b0, a_prev_en = 1'b0, b_prev_valid = 1'b0;
    logic [DW-1:0] a_prev_data = '0;

    always @(negedge clk) begin
        if (!a_cas_en && (a_cas_d0 != '0 || a_cas_d1 != '0)) a_viol++;
        if (a_busy && a_in_ready) a_viol++;
        if ((a_out_valid || a_cas_en) && !a_busy) a_viol++;
        if (a_cas_en && a_prev_en) a_viol++;
        if (a_prev_valid && !a_prev_ready && a_out_valid && a_out_data != a_prev_data) a_viol++;
        if (a_cas_en) a_en_q.push_back(cyc);
        if (a_out_valid && !a_prev_valid) a_val_q.push_back(cyc);
        a_prev_valid = a_out_valid;
        a_prev_ready = a_out_ready;
        a_prev_en    = a_cas_en;
        a_prev_data  = a_out_data;
        if (!b_cas_en && (b_cas_d0 != '0 || b_cas_d1 != '0)) b_viol++;
        if (b_busy && b_in_ready) b_viol++;
        if (b_cas_en) b_en_q.push_back(cyc);
        if (b_out_valid && !b_prev_valid) b_val_q.push_back(cyc);
        b_prev_valid = b_out_valid;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [KW-1:0] k_arr [N];
    logic [TW-1:0] t_arr [N];
    logic [DW-1:0] rec_a [N];
    int            c_last;

    // Loads rec_a[0..cnt-1] with a given valid density; returns the number accepted.
    task automatic load_a(input int cnt, input int vpct, output int loaded);
        int t;
        loaded = 0;
        t = 0;
        while (loaded < cnt && t < 1000) begin
            a_in_valid = ($urandom_range(99) < vpct);
            a_in_data  = a_in_valid ? rec_a[loaded] : DW'({$urandom, $urandom});
            if (a_in_valid && a_in_ready) begin
                c_last = cyc;
                loaded++;
            end
            @(posedge clk); #2;
            t++;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic run_a(input string name, input int vpct, input int rpct);
        logic [DW-1:0] exp_q [N];
        logic [DW-1:0] tmp;
        int            j, inv, loaded, got_n, t;
        int            en_base, val_base, sw_base, viol_base;
        for (int i = 0; i < N; i++) rec_a[i] = {k_arr[i], t_arr[i]};
        // Reference: stable insertion sort by key, and strict-inversion count.
        for (int i = 0; i < N; i++) exp_q[i] = rec_a[i];
        for (int i = 1; i < N; i++) begin
            tmp = exp_q[i];
            j = i - 1;
            while (j >= 0 && exp_q[j][DW-1 -: KW] > tmp[DW-1 -: KW]) begin
                exp_q[j+1] = exp_q[j];
                j--;
            end
            exp_q[j+1] = tmp;
        end
        inv = 0;
        for (int i = 0; i < N; i++)
            for (int k = i + 1; k < N; k++)
                if (k_arr[i] > k_arr[k]) inv++;
        en_base   = a_en_q.size();
        val_base  = a_val_q.size();
        sw_base   = a_swaps;
        viol_base = a_viol;
        load_a(N, vpct, loaded);
        check_val({name, " load_count"}, loaded, N);
        got_n = 0;
        t = 0;
        while (got_n < N && t < 3000) begin
            a_in_valid  = $urandom_range(1);
            a_in_data   = DW'({$urandom, $urandom});
            a_out_ready = ($urandom_range(99) < rpct);
            if (a_out_valid && a_out_ready) begin
                check_val($sformatf("%s out_data[%0d]", name, got_n), a_out_data, exp_q[got_n]);
                check_val($sformatf("%s out_last[%0d]", name, got_n), a_out_last, (got_n == N - 1));
                got_n++;
            end
            @(posedge clk); #2;
            t++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        check_val({name, " drain_count"}, got_n, N);
        check_val({name, " ready_after_drain"}, a_in_ready, 1);
        check_val({name, " valid_after_drain"}, a_out_valid, 0);
        check_val({name, " cas_pulses"}, a_en_q.size() - en_base, N * (N - 1) / 2);
        if (a_en_q.size() > en_base) begin
            check_val({name, " first_cas_cycle"}, a_en_q[en_base], c_last + 1);
            check_val({name, " last_cas_cycle"}, a_en_q[$], c_last + SORT_CYC - 1);
        end
        check_val({name, " valid_rises"}, a_val_q.size() - val_base, 1);
        if (a_val_q.size() > val_base)
            check_val({name, " first_valid_cycle"}, a_val_q[val_base], c_last + SORT_CYC + 1);
        check_val({name, " swaps"}, a_swaps - sw_base, inv);
        check_val({name, " protocol_viol"}, a_viol - viol_base, 0);
    endtask

    task automatic run_b(input string name, input logic [DW2-1:0] k0, input logic [DW2-1:0] k1);
        logic [DW2-1:0] e [2];
        int             got_n, t, en_base, val_base, cb;
        e[0] = (k0 > k1) ? k1 : k0;
        e[1] = (k0 > k1) ? k0 : k1;
        en_base  = b_en_q.size();
        val_base = b_val_q.size();
        cb = 0;
        for (int i = 0; i < 2; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = (i == 0) ? k0 : k1;
            t = 0;
            while (!b_in_ready && t < 100) begin
                @(posedge clk); #2;
                t++;
            end
            cb = cyc;
            @(posedge clk); #2;
        end
        b_in_valid = 1'b0;
        got_n = 0;
        t = 0;
        while (got_n < 2 && t < 200) begin
            b_out_ready = $urandom_range(1);
            if (b_out_valid && b_out_ready) begin
                check_val($sformatf("%s out_data[%0d]", name, got_n), b_out_data, e[got_n]);
                check_val($sformatf("%s out_last[%0d]", name, got_n), b_out_last, (got_n == 1));
                got_n++;
            end
            @(posedge clk); #2;
            t++;
        end
        b_out_ready = 1'b0;
        check_val({name, " drain_count"}, got_n, 2);
        check_val({name, " cas_pulses"}, b_en_q.size() - en_base, 1);
        if (b_en_q.size() > en_base)
            check_val({name, " cas_cycle"}, b_en_q[en_base], cb + 1);
        if (b_val_q.size() > val_base)
            check_val({name, " first_valid_cycle"}, b_val_q[val_base], cb + 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int loaded;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst in_ready", a_in_ready, 0);
        check_val("rst busy", a_busy, 0);
        check_val("rst out_valid", a_out_valid, 0);
        check_val("rst out_last", a_out_last, 0);
        check_val("rst cas_en", a_cas_en, 0);
        check_val("rst cas_data", {a_cas_d0[31:0], a_cas_d1[31:0]}, 0);
        check_val("rst b_in_ready", b_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check_val("rel in_ready", a_in_ready, 1);
        check_val("rel b_in_ready", b_in_ready, 1);
        @(posedge clk); #2;

        for (int i = 0; i < N; i++) begin k_arr[i] = KW'(N - 1 - i); t_arr[i] = '0; end
        run_a("reversed", 100, 100);
        for (int i = 0; i < N; i++) begin k_arr[i] = KW'(i); t_arr[i] = '0; end
        run_a("sorted", 100, 100);
        k_arr = '{32'd3, 32'd1, 32'd3, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0};
        for (int i = 0; i < N; i++) t_arr[i] = TW'(i);
        run_a("dup_keys", 100, 100);
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < N; i++) begin
                k_arr[i] = (b % 2 == 1) ? KW'($urandom) : KW'($urandom_range(7));
                t_arr[i] = TW'(i);
            end
            run_a($sformatf("random%0d", b), 50, 30);
        end

        // Reset in the middle of SORT, then a fresh batch 15..8.
        for (int i = 0; i < N; i++) rec_a[i] = {KW'(N - 1 - i), TW'(0)};
        load_a(N, 100, loaded);
        check_val("midsort load_count", loaded, N);
        while (cyc < c_last + 21) begin @(posedge clk); #2; end
        check_val("midsort pre_rst cas_en", a_cas_en, 1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check_val("midsort cas_en", a_cas_en, 0);
        check_val("midsort busy", a_busy, 0);
        check_val("midsort in_ready_in_rst", a_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check_val("midsort in_ready_rel", a_in_ready, 1);
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) begin k_arr[i] = KW'(15 - i); t_arr[i] = TW'(i); end
        run_a("after_rst", 100, 100);

        // Reset with a partially loaded batch: the next batch must start at index 0.
        for (int i = 0; i < N; i++) rec_a[i] = {KW'(100 + i), TW'(8'hAA)};
        load_a(3, 100, loaded);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) begin k_arr[i] = KW'($urandom_range(20)); t_arr[i] = TW'(i); end
        run_a("after_partial", 50, 30);

        run_b("n2_9_4", 32'd9, 32'd4);
        run_b("n2_equal", 32'd5, 32'd5);
        run_b("n2_random", $urandom, $urandom);
        check_val("n2 protocol_viol", b_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
